// File: rtl/pwm_duty_sequencer.sv
// Shares the PWM core register bus between the host adapter and a duty-cycle
// ramp sequencer; the host always wins and the sequencer writes only into idle bus cycles.
module pwm_duty_sequencer #(
  parameter int unsigned   AW        = 8,
  parameter int unsigned   DW        = 32,
  parameter int unsigned   DBW       = DW / 8,
  parameter int unsigned   HW        = 16,
  parameter logic [AW-1:0] DUTY_ADDR = 8'h08
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           host_re_i,
  input  logic           host_we_i,
  input  logic [AW-1:0]  host_addr_i,
  input  logic [DW-1:0]  host_wdata_i,
  input  logic [DBW-1:0] host_be_i,
  output logic [DW-1:0]  host_rdata_o,
  output logic           host_error_o,
  output logic           reg_re_o,
  output logic           reg_we_o,
  output logic [AW-1:0]  reg_addr_o,
  output logic [DW-1:0]  reg_wdata_o,
  output logic [DBW-1:0] reg_be_o,
  input  logic [DW-1:0]  reg_rdata_i,
  input  logic           reg_error_i,
  input  logic           seq_start_i,
  input  logic           seq_abort_i,
  input  logic [DW-1:0]  seq_start_duty_i,
  input  logic [DW-1:0]  seq_end_duty_i,
  input  logic [DW-1:0]  seq_step_i,
  input  logic [HW-1:0]  seq_hold_i,
  output logic           seq_busy_o,
  output logic           seq_done_o,
  output logic           seq_err_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] cur_q, cur_d;
  logic [DW-1:0] end_q, end_d;
  logic [DW-1:0] step_q, step_d;
  logic          up_q, up_d;
  logic [HW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          host_act_s;
  logic          grant_s;

  // Saturating step toward the target; a zero step or a short remaining gap lands on the target.
  function automatic logic [DW-1:0] next_duty(input logic [DW-1:0] cur,
                                              input logic [DW-1:0] fin,
                                              input logic [DW-1:0] step,
                                              input logic          up);
    logic [DW-1:0] gap;
    gap = up ? (fin - cur) : (cur - fin);
    if ((step == {DW{1'b0}}) || (gap <= step)) begin
      return fin;
    end else if (up) begin
      return cur + step;
    end else begin
      return cur - step;
    end
  endfunction

  assign host_act_s = host_re_i | host_we_i;
  // An abort in the same cycle cancels the pending write.
  assign grant_s    = (state_q == WRITE) & ~host_act_s & ~seq_abort_i;

  // Bus mux: sequencer grant, host pass-through, or a fully quiet bus.
  always_comb begin
    reg_re_o     = 1'b0;
    reg_we_o     = 1'b0;
    reg_addr_o   = {AW{1'b0}};
    reg_wdata_o  = {DW{1'b0}};
    reg_be_o     = {DBW{1'b0}};
    host_rdata_o = reg_rdata_i;
    host_error_o = reg_error_i;
    if (grant_s) begin
      reg_we_o     = 1'b1;
      reg_addr_o   = DUTY_ADDR;
      reg_wdata_o  = cur_q;
      reg_be_o     = {DBW{1'b1}};
      host_rdata_o = {DW{1'b0}};
      host_error_o = 1'b0;
    end else if (host_act_s) begin
      reg_re_o    = host_re_i;
      reg_we_o    = host_we_i;
      reg_addr_o  = host_addr_i;
      reg_wdata_o = host_wdata_i;
      reg_be_o    = host_be_i;
    end else begin
      reg_re_o = 1'b0;
      reg_we_o = 1'b0;
    end
  end

  // Sequencer next-state and pulse generation.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    end_d   = end_q;
    step_d  = step_q;
    up_d    = up_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (seq_start_i) begin
          cur_d   = seq_start_duty_i;
          end_d   = seq_end_duty_i;
          step_d  = seq_step_i;
          up_d    = (seq_end_duty_i >= seq_start_duty_i);
          state_d = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (seq_abort_i) begin
          state_d = IDLE;
        end else if (grant_s) begin
          if (reg_error_i) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else if (cur_q == end_q) begin
            state_d = DONE;
          end else begin
            cnt_d   = seq_hold_i;
            state_d = HOLD;
          end
        end else begin
          state_d = WRITE;
        end
      end
      HOLD: begin
        if (seq_abort_i) begin
          state_d = IDLE;
        end else if (cnt_q == {HW{1'b0}}) begin
          cur_d   = next_duty(cur_q, end_q, step_q, up_q);
          state_d = WRITE;
        end else begin
          cnt_d   = cnt_q - {{(HW-1){1'b0}}, 1'b1};
          state_d = HOLD;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cur_q   <= {DW{1'b0}};
      end_q   <= {DW{1'b0}};
      step_q  <= {DW{1'b0}};
      up_q    <= 1'b0;
      cnt_q   <= {HW{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      end_q   <= end_d;
      step_q  <= step_d;
      up_q    <= up_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign seq_busy_o = busy_q;
  assign seq_done_o = done_q;
  assign seq_err_o  = err_q;

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Randomised and directed checks of pwm_duty_sequencer against a ramp model that
// derives write values and cycles from start/end/step/hold and the host traffic pattern.
module tb_pwm_duty_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        host_re_i, host_we_i;
  logic [7:0]  host_addr_i;
  logic [31:0] host_wdata_i;
  logic [3:0]  host_be_i;
  logic [31:0] host_rdata_o;
  logic        host_error_o;
  logic        reg_re_o, reg_we_o;
  logic [7:0]  reg_addr_o;
  logic [31:0] reg_wdata_o;
  logic [3:0]  reg_be_o;
  logic [31:0] reg_rdata_i;
  logic        reg_error_i;
  logic        seq_start_i, seq_abort_i;
  logic [31:0] seq_start_duty_i, seq_end_duty_i, seq_step_i;
  logic [15:0] seq_hold_i;
  logic        seq_busy_o, seq_done_o, seq_err_o;

  int          n_chk = 0;
  int          n_bad = 0;
  int          rel_g = 0;
  int          err_idx = -1;
  int          wr_cnt = 0;
  logic        bus_err = 1'b0;
  logic        last_busy;
  bit          host_pat [0:4095];
  logic [31:0] wr_v[$];
  int          wr_c[$];
  int          dn_c[$];
  int          er_c[$];

  // Core-side slave: errors the chosen sequencer write, random error on host accesses.
  assign reg_error_i = (reg_we_o && !host_we_i && !host_re_i) ? (err_idx == wr_cnt) : bus_err;

  always #5 clk_i = ~clk_i;

  pwm_duty_sequencer dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .host_re_i(host_re_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i),
    .host_wdata_i(host_wdata_i), .host_be_i(host_be_i),
    .host_rdata_o(host_rdata_o), .host_error_o(host_error_o),
    .reg_re_o(reg_re_o), .reg_we_o(reg_we_o), .reg_addr_o(reg_addr_o),
    .reg_wdata_o(reg_wdata_o), .reg_be_o(reg_be_o),
    .reg_rdata_i(reg_rdata_i), .reg_error_i(reg_error_i),
    .seq_start_i(seq_start_i), .seq_abort_i(seq_abort_i),
    .seq_start_duty_i(seq_start_duty_i), .seq_end_duty_i(seq_end_duty_i),
    .seq_step_i(seq_step_i), .seq_hold_i(seq_hold_i),
    .seq_busy_o(seq_busy_o), .seq_done_o(seq_done_o), .seq_err_o(seq_err_o)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: sample at the falling edge, then step past the rising edge.
  task automatic cyc();
    @(negedge clk_i);
    if (host_we_i || host_re_i) begin
      check_val("pt_we", reg_we_o, host_we_i);
      check_val("pt_re", reg_re_o, host_re_i);
      check_val("pt_addr", reg_addr_o, host_addr_i);
      check_val("pt_wdata", reg_wdata_o, host_wdata_i);
      check_val("pt_be", reg_be_o, host_be_i);
      check_val("pt_rdata", host_rdata_o, reg_rdata_i);
      check_val("pt_err", host_error_o, reg_error_i);
    end else if (reg_we_o) begin
      check_val("gr_addr", reg_addr_o, 8'h08);
      check_val("gr_be", reg_be_o, 4'hF);
      check_val("gr_re", reg_re_o, 1'b0);
      check_val("gr_rdata", host_rdata_o, 32'h0);
      check_val("gr_herr", host_error_o, 1'b0);
      wr_v.push_back(reg_wdata_o);
      wr_c.push_back(rel_g);
    end else begin
      check_val("idle_bus", {reg_re_o, reg_addr_o, reg_wdata_o, reg_be_o}, 45'h0);
      check_val("idle_rdata", host_rdata_o, reg_rdata_i);
    end
    if (seq_done_o) dn_c.push_back(rel_g);
    if (seq_err_o) er_c.push_back(rel_g);
    last_busy = seq_busy_o;
    @(posedge clk_i);
    #1;
    wr_cnt = wr_v.size();
  endtask

  task automatic clear_rec();
    wr_v.delete(); wr_c.delete(); dn_c.delete(); er_c.delete();
    wr_cnt = 0;
  endtask

  // pct<0 selects the fixed contention pattern (host writes to 0x04 in cycles 1..3).
  task automatic run_seq(input logic [31:0] s, input logic [31:0] e, input logic [31:0] st,
                         input logic [15:0] h, input int err_at, input int abort_at,
                         input int restart_at, input bit abort0, input int pct);
    logic [31:0] ev[$];
    int          ec[$];
    logic [31:0] v;
    int          c, term, exp_done, exp_err;
    for (int i = 0; i < 4096; i++)
      host_pat[i] = (pct < 0) ? (i >= 1 && i <= 3) : ((pct > 0) && ($urandom_range(0, 99) < pct));
    v = s;
    ev.push_back(v);
    while (v != e) begin
      if (st == 32'd0 || ((e >= s) ? (e - v) : (v - e)) <= st) v = e;
      else if (e >= s) v = v + st;
      else v = v - st;
      ev.push_back(v);
    end
    c = 1;
    foreach (ev[i]) begin
      while (c < 4095 && host_pat[c]) c++;
      ec.push_back(c);
      c = c + int'(h) + 2;
    end
    exp_done = -1;
    exp_err  = -1;
    if (err_at >= 0) begin
      while (ev.size() > err_at + 1) begin void'(ev.pop_back()); void'(ec.pop_back()); end
      exp_err = ec[err_at] + 1;
      term = exp_err;
    end else if (abort_at >= 1) begin
      while (ec.size() > 0 && ec[$] >= abort_at) begin void'(ev.pop_back()); void'(ec.pop_back()); end
      term = abort_at + 1;
    end else begin
      exp_done = ec[$] + 1;
      term = exp_done + 1;
    end
    err_idx = err_at;
    clear_rec();
    for (int r = 0; r <= term + 3; r++) begin
      rel_g = r;
      seq_start_i = (r == 0) || (r == restart_at);
      seq_abort_i = (r == abort_at) || (abort0 && r == 0);
      if (r == 0) begin
        seq_start_duty_i = s; seq_end_duty_i = e; seq_step_i = st;
      end else begin
        seq_start_duty_i = $urandom; seq_end_duty_i = $urandom; seq_step_i = $urandom;
      end
      seq_hold_i = h;
      host_we_i = 1'b0; host_re_i = 1'b0;
      host_addr_i = 8'($urandom); host_wdata_i = $urandom; host_be_i = 4'($urandom);
      if (r < 4096 && host_pat[r]) begin
        if (pct < 0) begin
          host_we_i = 1'b1; host_addr_i = 8'h04;
        end else if ($urandom_range(0, 1) == 0) begin
          host_we_i = 1'b1;
        end else begin
          host_re_i = 1'b1; host_addr_i = 8'h08;
        end
      end
      reg_rdata_i = $urandom;
      bus_err = 1'($urandom_range(0, 1));
      cyc();
      if (r == 1) check_val("busy_on", last_busy, 1'b1);
      if (r == term - 1) check_val("busy_last", last_busy, 1'b1);
      if (r == term) check_val("busy_off", last_busy, 1'b0);
    end
    check_val("n_writes", wr_v.size(), ev.size());
    for (int i = 0; i < ev.size() && i < wr_v.size(); i++) begin
      check_val("wr_val", wr_v[i], ev[i]);
      check_val("wr_cyc", wr_c[i], ec[i]);
    end
    check_val("n_done", dn_c.size(), (exp_done >= 0) ? 1 : 0);
    if (exp_done >= 0 && dn_c.size() > 0) check_val("done_cyc", dn_c[0], exp_done);
    check_val("n_err", er_c.size(), (exp_err >= 0) ? 1 : 0);
    if (exp_err >= 0 && er_c.size() > 0) check_val("err_cyc", er_c[0], exp_err);
    err_idx = -1;
  endtask

  initial begin
    rst_ni = 1'b0;
    host_re_i = 1'b0; host_we_i = 1'b0; host_addr_i = 8'h00; host_wdata_i = 32'h0; host_be_i = 4'h0;
    reg_rdata_i = 32'h0; seq_start_i = 1'b0; seq_abort_i = 1'b0;
    seq_start_duty_i = 32'h0; seq_end_duty_i = 32'h0; seq_step_i = 32'h0; seq_hold_i = 16'h0;
    repeat (3) @(posedge clk_i);
    #1;
    check_val("rst_busy", seq_busy_o, 1'b0);
    check_val("rst_done", seq_done_o, 1'b0);
    check_val("rst_err", seq_err_o, 1'b0);
    check_val("rst_we", reg_we_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    run_seq(32'd0, 32'd100, 32'd30, 16'd2, -1, -1, -1, 1'b0, 0);
    run_seq(32'd50, 32'd5, 32'd20, 16'd0, -1, -1, -1, 1'b0, 0);
    run_seq(32'd0, 32'd100, 32'd30, 16'd2, -1, -1, -1, 1'b0, -1);
    run_seq(32'd0, 32'd100, 32'd30, 16'd2, 1, -1, -1, 1'b0, 0);
    run_seq(32'd0, 32'd100, 32'd30, 16'd2, -1, 7, 3, 1'b0, 0);
    run_seq(32'd7, 32'd7, 32'd3, 16'd4, -1, -1, -1, 1'b1, 0);
    run_seq(32'd10, 32'd200, 32'd0, 16'd1, -1, -1, -1, 1'b0, 0);
    run_seq(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'd10, 16'd0, -1, -1, -1, 1'b0, 0);
    run_seq(32'd15, 32'd0, 32'd10, 16'd1, -1, -1, -1, 1'b0, 0);

    for (int k = 0; k < 10; k++) begin
      logic [31:0] rs, re, rst;
      rs  = $urandom_range(0, 300);
      re  = $urandom_range(0, 300);
      rst = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom_range(15, 80));
      run_seq(rs, re, rst, 16'($urandom_range(0, 5)), -1, -1, -1, 1'b0, (k % 3) * 15);
    end

    // Asynchronous reset in the middle of a ramp.
    seq_start_duty_i = 32'd0; seq_end_duty_i = 32'd100; seq_step_i = 32'd30; seq_hold_i = 16'd2;
    host_we_i = 1'b0; host_re_i = 1'b0;
    clear_rec();
    seq_start_i = 1'b1;
    cyc();
    seq_start_i = 1'b0;
    repeat (4) cyc();
    @(negedge clk_i);
    #2;
    rst_ni = 1'b0;
    #1;
    check_val("arst_busy", seq_busy_o, 1'b0);
    check_val("arst_we", reg_we_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    clear_rec();
    repeat (8) cyc();
    check_val("arst_nowr", wr_v.size(), 0);
    check_val("arst_idle", last_busy, 1'b0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/pwm_duty_sequencer.md
Name: pwm_duty_sequencer

Overview:
- Owns the PWM core's register bus and shares it between two masters:
  - the host path, from the TL-UL register adapter;
  - an internal duty-cycle ramp sequencer.
- The sequencer steps the PWM duty register from a start value to an end value. It waits a programmable hold between steps, which gives hardware fades without CPU involvement.
- Sits between the TL-UL register adapter and the PWM core inside the PWM top level.

Parameters:
- AW, 8, register address width.
- DW, 32, register data width.
- DBW, DW/8, byte-enable width.
- HW, 16, hold counter width.
- DUTY_ADDR, 8'h08, PWM duty register address targeted by the sequencer.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- host_re_i  in  1  host read strobe.
- host_we_i  in  1  host write strobe.
- host_addr_i  in  AW  host address.
- host_wdata_i  in  DW  host write data.
- host_be_i  in  DBW  host byte enables.
- host_rdata_o  out  DW  host read data.
- host_error_o  out  1  host error.
- reg_re_o  out  1  core read strobe.
- reg_we_o  out  1  core write strobe.
- reg_addr_o  out  AW  core address.
- reg_wdata_o  out  DW  core write data.
- reg_be_o  out  DBW  core byte enables.
- reg_rdata_i  in  DW  core read data, valid in the same cycle as reg_re_o.
- reg_error_i  in  1  core error, valid in the same cycle as the strobe.
- seq_start_i  in  1  start pulse.
- seq_abort_i  in  1  abort pulse.
- seq_start_duty_i  in  DW  first duty value.
- seq_end_duty_i  in  DW  final duty value.
- seq_step_i  in  DW  unsigned step size.
- seq_hold_i  in  HW  hold cycles between writes.
- seq_busy_o  out  1  sequence in progress.
- seq_done_o  out  1  one-cycle pulse on completion.
- seq_err_o  out  1  one-cycle pulse when a sequencer write errors.

Behaviour:
- Clocking and reset: single clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset values: state IDLE; all registered outputs 0 (seq_busy_o, seq_done_o, seq_err_o); the current-duty, end, step and hold counter registers are 0.
- Host path is combinational pass-through. The reg_* outputs mirror the host_* inputs, except reg_we_o/reg_wdata_o/reg_addr_o/reg_be_o are overridden on a sequencer grant cycle.
- host_rdata_o = reg_rdata_i and host_error_o = reg_error_i whenever no sequencer grant is active that cycle. On a grant cycle both are 0.
- With no host strobe and no grant, reg_* outputs are all 0.
- Arbitration is fixed priority to the host. The sequencer is granted only in WRITE when host_re_i=0 and host_we_i=0. Otherwise it stalls in WRITE with no loss of state.
- Grant cycle drives: reg_we_o=1, reg_re_o=0, reg_addr_o=DUTY_ADDR, reg_wdata_o=cur, reg_be_o=all ones.
- FSM states: IDLE, WRITE, HOLD, DONE.
  - IDLE: seq_start_i latches cur=start, end, step and direction (up if end>=start); go to WRITE. seq_start_i is ignored in every other state.
  - WRITE: on grant, if reg_error_i=1, pulse seq_err_o the next cycle and go to IDLE. Else if cur==end, go to DONE. Else load cnt=seq_hold_i (sampled at the grant) and go to HOLD.
  - HOLD: if cnt==0, update cur and go to WRITE; else cnt-=1. HOLD lasts hold+1 cycles, so consecutive writes with no host contention are hold+2 cycles apart.
  - DONE: seq_done_o=1 for this one cycle, then go to IDLE.
- seq_busy_o=1 in WRITE, HOLD and DONE.
- Step arithmetic is DW-bit unsigned with no wrap and never overshoots end.
  - Up: cur = (end-cur <= step) ? end : cur+step.
  - Down: cur = (cur-end <= step) ? end : cur-step.
  - step==0 jumps directly to end on the next update.
- start==end gives exactly one write, then DONE.
- Abort: seq_abort_i in any non-IDLE state forces IDLE on the next edge. In that cycle there is no grant and no done or err pulse; abort beats a pending grant in the same cycle. Abort in IDLE has no effect.
- Simultaneous start and abort in IDLE: start wins.
- Reset mid-sequence: returns to IDLE immediately (asynchronous); no bus write.

Test Plan:
- Ramp up: start=0, end=100, step=30, hold=2, no host traffic -> DUTY_ADDR writes 0, 30, 60, 90, 100 at cycles t, t+4, t+8, t+12, t+16. seq_done_o pulses at t+17; seq_busy_o falls at t+18.
- Ramp down with saturation: start=50, end=5, step=20, hold=0 -> writes 50, 30, 10, 5, each 2 cycles apart; exactly 4 writes; done pulses once.
- Host contention: during WRITE, hold host_we_i=1 (addr 8'h04) for 3 cycles -> core sees the 3 host writes unchanged; sequencer write of the pending value is issued the cycle after host_we_i drops; the following HOLD timing is unaffected.
- Error: reg_error_i=1 on the second sequencer write -> seq_err_o pulses once, FSM goes to IDLE, no further writes, seq_done_o never asserts, host_error_o=0 during that grant.
- Abort and restart: abort in HOLD after the second write -> no further writes, busy low next cycle. A new start (start=7, end=7) then gives a single write of 7 and a done pulse. seq_start_i asserted while busy is ignored.
- Host read pass-through: host_re_i=1, addr 8'h08, reg_rdata_i=32'hA5 while the sequencer is in HOLD -> host_rdata_o=32'hA5 in the same cycle.
